// File: rtl/pll_cen_pkg.sv
// rtl/pll_cen_pkg.sv - shared types and defaults for the clock-enable generator
package pll_cen_pkg;

  localparam int ACC_W_DEF   = 24;
  localparam int PHASE_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_LOCKED
  } pll_state_t;

  typedef struct packed {
    logic [ACC_W_DEF-1:0]   inc;
    logic [ACC_W_DEF-1:0]   mod;
    logic [PHASE_W_DEF-1:0] phase;
  } chan_cfg_t;

endpackage

// File: rtl/pll_cen_chan.sv
// rtl/pll_cen_chan.sv - one fractional enable channel (accumulator, phase delay, ce/toggle)
module pll_cen_chan
  import pll_cen_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int PHASE_W = PHASE_W_DEF
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               arm,
  input  logic               flush,
  input  logic               run,
  input  logic [ACC_W-1:0]   cfg_inc,
  input  logic [ACC_W-1:0]   cfg_mod,
  input  logic [PHASE_W-1:0] cfg_phase,
  output logic               ce,
  output logic               tgl,
  output logic               err
);

  logic [ACC_W-1:0]   inc_q;
  logic [ACC_W-1:0]   mod_q;
  logic [ACC_W-1:0]   acc;
  logic [PHASE_W-1:0] phase_cnt;
  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   acc_wrap;
  logic               cfg_bad;

  // One extra bit keeps acc+inc exact; the wrapped value is always below mod so ACC_W bits suffice
  always_comb begin
    sum      = {1'b0, acc} + {1'b0, inc_q};
    acc_wrap = sum[ACC_W-1:0] - mod_q;
    cfg_bad  = (cfg_inc >= cfg_mod) || (cfg_mod == '0);
  end

  // Arm loads the new ratio and realigns; flush silences ce for the arm cycle; run steps the accumulator
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      inc_q     <= '0;
      mod_q     <= ACC_W'(1);
      acc       <= '0;
      phase_cnt <= '0;
      ce        <= 1'b0;
      tgl       <= 1'b0;
      err       <= 1'b0;
    end else if (arm) begin
      inc_q     <= cfg_inc;
      mod_q     <= cfg_mod;
      acc       <= '0;
      phase_cnt <= cfg_phase;
      err       <= cfg_bad;
      ce        <= cfg_bad;
      tgl       <= cfg_bad;
    end else if (flush) begin
      ce <= 1'b0;
    end else if (run) begin
      if (err) begin
        ce  <= 1'b1;
        tgl <= ~tgl;
      end else if (phase_cnt != '0) begin
        phase_cnt <= phase_cnt - 1'b1;
        ce        <= 1'b0;
      end else if (sum >= {1'b0, mod_q}) begin
        acc <= acc_wrap;
        ce  <= 1'b1;
        tgl <= ~tgl;
      end else begin
        acc <= sum[ACC_W-1:0];
        ce  <= 1'b0;
      end
    end else begin
      ce <= 1'b0;
    end
  end

endmodule

// File: rtl/pll_cen_gen.sv
// rtl/pll_cen_gen.sv - multi-channel fractional clock-enable generator with lock indication
module pll_cen_gen
  import pll_cen_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int ACC_W       = ACC_W_DEF,
  parameter int PHASE_W     = PHASE_W_DEF,
  parameter int LOCK_CYCLES = 1024,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [ACC_W-1:0]   cfg_inc,
  input  logic [ACC_W-1:0]   cfg_mod,
  input  logic [PHASE_W-1:0] cfg_phase,
  input  logic               cfg_commit,
  output logic [NUM_CH-1:0]  ce_out,
  output logic [NUM_CH-1:0]  tgl_out,
  output logic [NUM_CH-1:0]  cfg_err,
  output logic               locked
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);

  pll_state_t         state;
  logic [CNT_W-1:0]   settle_cnt;
  logic               commit_take;
  logic               arm;
  logic               run;
  logic [ACC_W-1:0]   sh_inc   [NUM_CH];
  logic [ACC_W-1:0]   sh_mod   [NUM_CH];
  logic [PHASE_W-1:0] sh_phase [NUM_CH];

  // Commit is honoured everywhere except the arm cycle itself
  always_comb begin
    commit_take = cfg_commit && (state != ST_ARM);
    arm         = (state == ST_ARM);
    run         = (state == ST_RUN) || (state == ST_LOCKED);
  end

  // Sequencer: idle until commit, one arm cycle, then settle count to lock
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      locked     <= 1'b0;
      cfg_ready  <= 1'b0;
    end else begin
      cfg_ready <= !commit_take;
      case (state)
        ST_ARM: begin
          state      <= ST_RUN;
          settle_cnt <= '0;
          locked     <= 1'b0;
          cfg_ready  <= 1'b1;
        end
        ST_RUN: begin
          if (commit_take) begin
            state <= ST_ARM;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
            if (settle_cnt == LOCK_LAST) begin
              state  <= ST_LOCKED;
              locked <= 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (commit_take) begin
            state  <= ST_ARM;
            locked <= 1'b0;
          end
        end
        default: begin
          if (commit_take) state <= ST_ARM;
        end
      endcase
    end
  end

  // Shadow registers take writes outside the arm cycle; the arm cycle copies them into the channels
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sh_inc[i]   <= '0;
        sh_mod[i]   <= ACC_W'(1);
        sh_phase[i] <= '0;
      end
    end else if (cfg_valid && cfg_ready && !arm) begin
      sh_inc[cfg_ch]   <= cfg_inc;
      sh_mod[cfg_ch]   <= cfg_mod;
      sh_phase[cfg_ch] <= cfg_phase;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    pll_cen_chan #(
      .ACC_W  (ACC_W),
      .PHASE_W(PHASE_W)
    ) u_chan (
      .refclk   (refclk),
      .rst_n    (rst_n),
      .arm      (arm),
      .flush    (commit_take),
      .run      (run),
      .cfg_inc  (sh_inc[g]),
      .cfg_mod  (sh_mod[g]),
      .cfg_phase(sh_phase[g]),
      .ce       (ce_out[g]),
      .tgl      (tgl_out[g]),
      .err      (cfg_err[g])
    );
  end

endmodule

// File: tb/tb_pll_cen_gen.sv
// tb/tb_pll_cen_gen.sv - self-checking bench for pll_cen_gen against a closed-form rate model
module tb_pll_cen_gen;

  localparam int NUM_CH  = 4;
  localparam int ACC_W   = 24;
  localparam int PHASE_W = 8;
  localparam int LOCK    = 16;

  logic               refclk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [1:0]         cfg_ch = '0;
  logic [ACC_W-1:0]   cfg_inc = '0;
  logic [ACC_W-1:0]   cfg_mod = '0;
  logic [PHASE_W-1:0] cfg_phase = '0;
  logic               cfg_commit = 1'b0;
  logic [NUM_CH-1:0]  ce_out;
  logic [NUM_CH-1:0]  tgl_out;
  logic [NUM_CH-1:0]  cfg_err;
  logic               locked;

  pll_cen_gen #(
    .NUM_CH     (NUM_CH),
    .ACC_W      (ACC_W),
    .PHASE_W    (PHASE_W),
    .LOCK_CYCLES(LOCK)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .cfg_mod   (cfg_mod),
    .cfg_phase (cfg_phase),
    .cfg_commit(cfg_commit),
    .ce_out    (ce_out),
    .tgl_out   (tgl_out),
    .cfg_err   (cfg_err),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  int n_checks = 0;
  int n_pass = 0;

  longint s_inc[NUM_CH], s_mod[NUM_CH], s_ph[NUM_CH];
  longint a_inc[NUM_CH], a_mod[NUM_CH], a_ph[NUM_CH];

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic shadow_defaults();
    for (int c = 0; c < NUM_CH; c++) begin
      s_inc[c] = 0; s_mod[c] = 1; s_ph[c] = 0;
      a_inc[c] = 0; a_mod[c] = 1; a_ph[c] = 0;
    end
  endtask

  task automatic wr(input int ch, input longint inc, input longint md, input longint ph);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_inc   = ACC_W'(inc);
    cfg_mod   = ACC_W'(md);
    cfg_phase = PHASE_W'(ph);
    step();
    cfg_valid = 1'b0;
    s_inc[ch] = inc; s_mod[ch] = md; s_ph[ch] = ph;
  endtask

  task automatic commit_model();
    for (int c = 0; c < NUM_CH; c++) begin
      a_inc[c] = s_inc[c]; a_mod[c] = s_mod[c]; a_ph[c] = s_ph[c];
    end
  endtask

  // Reference: after n accumulation steps a channel has emitted floor(n*inc/mod) pulses
  function automatic bit m_bad(int c);
    return (a_mod[c] == 0) || (a_inc[c] >= a_mod[c]);
  endfunction

  function automatic longint m_pulses(int c, int k);
    longint n;
    n = longint'(k) - 1 - a_ph[c];
    if (n < 1) return 0;
    return (n * a_inc[c]) / a_mod[c];
  endfunction

  function automatic logic [NUM_CH-1:0] m_ce(int k);
    logic [NUM_CH-1:0] v;
    longint n;
    for (int c = 0; c < NUM_CH; c++) begin
      n = longint'(k) - 1 - a_ph[c];
      if (m_bad(c)) v[c] = 1'b1;
      else if (n < 1) v[c] = 1'b0;
      else v[c] = (m_pulses(c, k) != m_pulses(c, k - 1));
    end
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] m_tgl(int k);
    logic [NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_bad(c)) v[c] = k[0];
      else v[c] = m_pulses(c, k) % 2 == 1;
    end
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] m_err();
    logic [NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = m_bad(c);
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step(); step();
    n_checks++;
    if ({ce_out, tgl_out, cfg_err, locked, cfg_ready} !== '0)
      $display("FAIL reset_outputs got ce=%b tgl=%b err=%b lk=%b rdy=%b exp all 0", ce_out, tgl_out, cfg_err, locked, cfg_ready);
    else n_pass++;
    rst_n = 1'b1;
    step();
    n_checks++;
    if (cfg_ready !== 1'b1) $display("FAIL idle_ready got %b exp 1", cfg_ready);
    else n_pass++;
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (ce_out !== '0 || locked !== 1'b0) $display("FAIL idle_silent ce=%b lk=%b exp 0/0", ce_out, locked);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_basic_rates();
    int cnt0, cnt1;
    wr(0, 1, 4, 0);
    wr(1, 3, 8, 0);
    wr(2, 2, 7, 0);
    wr(3, 5, 13, 1);
    cfg_commit = 1'b1; step(); cfg_commit = 1'b0; commit_model();
    n_checks++;
    if (ce_out !== '0 || locked !== 1'b0 || cfg_ready !== 1'b0)
      $display("FAIL basic_arm ce=%b lk=%b rdy=%b exp 0/0/0", ce_out, locked, cfg_ready);
    else n_pass++;
    step();
    cnt0 = 0; cnt1 = 0;
    for (int k = 1; k <= 8001; k++) begin
      if (k >= 2) begin cnt0 += int'(ce_out[0]); cnt1 += int'(ce_out[1]); end
      n_checks++;
      if (ce_out !== m_ce(k)) $display("FAIL basic_ce k=%0d got %b exp %b", k, ce_out, m_ce(k));
      else n_pass++;
      n_checks++;
      if (tgl_out !== m_tgl(k)) $display("FAIL basic_tgl k=%0d got %b exp %b", k, tgl_out, m_tgl(k));
      else n_pass++;
      n_checks++;
      if (locked !== (k > LOCK) || cfg_ready !== 1'b1)
        $display("FAIL basic_lock k=%0d got lk=%b rdy=%b exp lk=%b rdy=1", k, locked, cfg_ready, k > LOCK);
      else n_pass++;
      step();
    end
    n_checks++;
    if (cnt1 !== 3000) $display("FAIL basic_ch1_count got %0d exp 3000", cnt1);
    else n_pass++;
    n_checks++;
    if (cnt0 !== 2000) $display("FAIL basic_ch0_count got %0d exp 2000", cnt0);
    else n_pass++;
  endtask

  task automatic test_phase_commit_locked();
    // Write and commit land on the same edge; the write must be part of the commit
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 24'd1; cfg_mod = 24'd4; cfg_phase = 8'd2;
    cfg_commit = 1'b1;
    step();
    cfg_valid = 1'b0; cfg_commit = 1'b0;
    s_inc[0] = 1; s_mod[0] = 4; s_ph[0] = 2;
    commit_model();
    n_checks++;
    if (ce_out !== '0 || locked !== 1'b0 || cfg_ready !== 1'b0)
      $display("FAIL phase_arm ce=%b lk=%b rdy=%b exp 0/0/0", ce_out, locked, cfg_ready);
    else n_pass++;
    step();
    for (int k = 1; k <= 40; k++) begin
      n_checks++;
      if (ce_out !== m_ce(k) || tgl_out !== m_tgl(k))
        $display("FAIL phase_run k=%0d got ce=%b tgl=%b exp ce=%b tgl=%b", k, ce_out, tgl_out, m_ce(k), m_tgl(k));
      else n_pass++;
      n_checks++;
      if (locked !== (k > LOCK)) $display("FAIL phase_lock k=%0d got %b exp %b", k, locked, k > LOCK);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_err_and_shadow();
    wr(2, 5, 5, 0);
    // Commit held for two edges: the second one falls in the arm cycle and must be ignored
    cfg_commit = 1'b1; step(); commit_model();
    n_checks++;
    if (ce_out !== '0 || cfg_ready !== 1'b0) $display("FAIL err_arm ce=%b rdy=%b exp 0/0", ce_out, cfg_ready);
    else n_pass++;
    step();
    cfg_commit = 1'b0;
    n_checks++;
    if (cfg_err !== m_err()) $display("FAIL err_flag got %b exp %b", cfg_err, m_err());
    else n_pass++;
    for (int k = 1; k <= 40; k++) begin
      if (k == 10) begin
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 24'd7; cfg_mod = 24'd9; cfg_phase = 8'd0;
        s_inc[0] = 7; s_mod[0] = 9; s_ph[0] = 0;
      end
      if (k == 11) cfg_valid = 1'b0;
      n_checks++;
      if (ce_out !== m_ce(k) || tgl_out !== m_tgl(k))
        $display("FAIL err_run k=%0d got ce=%b tgl=%b exp ce=%b tgl=%b", k, ce_out, tgl_out, m_ce(k), m_tgl(k));
      else n_pass++;
      n_checks++;
      if (cfg_ready !== 1'b1 || locked !== (k > LOCK))
        $display("FAIL err_state k=%0d got rdy=%b lk=%b exp 1/%b", k, cfg_ready, locked, k > LOCK);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        longint md, inc, ph;
        if (c == 3) begin
          md  = 64'hFFFFFF;
          inc = longint'($urandom_range(24'hFFFFFE, 24'h800000));
        end else begin
          md  = ($urandom_range(0, 7) == 0) ? 0 : longint'($urandom_range(40, 1));
          inc = longint'($urandom_range(int'(md) + 1, 0));
        end
        ph = longint'($urandom_range(5, 0));
        wr(c, inc, md, ph);
      end
      cfg_commit = 1'b1; step(); cfg_commit = 1'b0; commit_model();
      n_checks++;
      if (ce_out !== '0 || locked !== 1'b0) $display("FAIL rand_arm r=%0d ce=%b lk=%b exp 0/0", r, ce_out, locked);
      else n_pass++;
      step();
      n_checks++;
      if (cfg_err !== m_err()) $display("FAIL rand_err r=%0d got %b exp %b", r, cfg_err, m_err());
      else n_pass++;
      for (int k = 1; k <= 60; k++) begin
        n_checks++;
        if (ce_out !== m_ce(k) || tgl_out !== m_tgl(k))
          $display("FAIL rand_run r=%0d k=%0d got ce=%b tgl=%b exp ce=%b tgl=%b", r, k, ce_out, tgl_out, m_ce(k), m_tgl(k));
        else n_pass++;
        n_checks++;
        if (locked !== (k > LOCK)) $display("FAIL rand_lock r=%0d k=%0d got %b exp %b", r, k, locked, k > LOCK);
        else n_pass++;
        step();
      end
    end
  endtask

  task automatic test_reset_mid();
    wr(2, 5, 5, 0);
    cfg_commit = 1'b1; step(); cfg_commit = 1'b0; commit_model();
    for (int k = 0; k < 25; k++) step();
    n_checks++;
    if (locked !== 1'b1 || cfg_err[2] !== 1'b1) $display("FAIL pre_reset got lk=%b err=%b exp 1/1", locked, cfg_err[2]);
    else n_pass++;
    @(posedge refclk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ce_out, tgl_out, cfg_err, locked, cfg_ready} !== '0)
      $display("FAIL async_reset got ce=%b tgl=%b err=%b lk=%b rdy=%b exp all 0", ce_out, tgl_out, cfg_err, locked, cfg_ready);
    else n_pass++;
    step(); step();
    rst_n = 1'b1;
    shadow_defaults();
    step();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (ce_out !== '0 || locked !== 1'b0) $display("FAIL post_reset_idle ce=%b lk=%b exp 0/0", ce_out, locked);
      else n_pass++;
      step();
    end
    cfg_commit = 1'b1; step(); cfg_commit = 1'b0; commit_model();
    step();
    for (int k = 1; k <= 30; k++) begin
      n_checks++;
      if (ce_out !== '0 || tgl_out !== '0 || cfg_err !== '0)
        $display("FAIL default_silent k=%0d got ce=%b tgl=%b err=%b exp 0", k, ce_out, tgl_out, cfg_err);
      else n_pass++;
      n_checks++;
      if (locked !== (k > LOCK)) $display("FAIL default_lock k=%0d got %b exp %b", k, locked, k > LOCK);
      else n_pass++;
      step();
    end
  endtask

  initial begin
    shadow_defaults();
    test_reset();
    test_basic_rates();
    test_phase_commit_locked();
    test_err_and_shadow();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
